// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// id_ex_stage_pkg: shared control packing and width defaults for the ID/EX stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_RW   = 5;
  localparam int DEF_AOPW = 4;

  // Bit order matches {reg_write,mem_to_reg,mem_read,mem_write,alu_src,reg_dst}
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect_unit.sv
// ============================================================================
// hazard_detect_unit: combinational load-use detector between EX and ID
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detect_unit #(
  parameter int RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_uses_rt,
  output logic          hazard
);

  logic rt_nonzero;
  logic rs_match;
  logic rt_match;

  // A load targeting $zero produces nothing worth waiting for
  assign rt_nonzero = (ex_rt != '0);
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = id_uses_rt & (ex_rt == id_rt);

  assign hazard = id_valid & ex_valid & ex_mem_read & rt_nonzero & (rs_match | rt_match);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int RW   = DEF_RW,
  parameter int AOPW = DEF_AOPW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DW-1:0]     id_pc4_i,
  input  logic [DW-1:0]     id_rd1_i,
  input  logic [DW-1:0]     id_rd2_i,
  input  logic [DW-1:0]     id_imm_i,
  input  logic [RW-1:0]     id_rs_i,
  input  logic [RW-1:0]     id_rt_i,
  input  logic [RW-1:0]     id_rd_i,
  input  logic              id_uses_rt_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [AOPW-1:0]   id_aluop_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [DW-1:0]     ex_pc4_o,
  output logic [DW-1:0]     ex_rd1_o,
  output logic [DW-1:0]     ex_rd2_o,
  output logic [DW-1:0]     ex_imm_o,
  output logic [RW-1:0]     ex_rs_o,
  output logic [RW-1:0]     ex_rt_o,
  output logic [RW-1:0]     ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [AOPW-1:0]   ex_aluop_o,
  output logic              ex_alu_src_o
);

  ctrl_t ex_ctrl_q;
  logic  hazard;
  logic  bubble;

  hazard_detect_unit #(
    .RW(RW)
  ) u_hazard_detect_unit (
    .ex_valid    (ex_valid_o),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rt       (ex_rt_o),
    .id_valid    (id_valid_i),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .id_uses_rt  (id_uses_rt_i),
    .hazard      (hazard)
  );

  // A flushed slot is discarded anyway, so holding ID upstream would only waste a cycle
  assign stall_o = hazard & ~flush_i;
  assign bubble  = flush_i | hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o <= 1'b0;
      ex_pc4_o   <= '0;
      ex_rd1_o   <= '0;
      ex_rd2_o   <= '0;
      ex_imm_o   <= '0;
      ex_rs_o    <= '0;
      ex_rt_o    <= '0;
      ex_rd_o    <= '0;
      ex_ctrl_q  <= '0;
      ex_aluop_o <= '0;
    end else if (bubble) begin
      // Data fields hold: only the control side must be neutralised
      ex_valid_o <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_aluop_o <= '0;
    end else begin
      ex_valid_o <= id_valid_i;
      ex_pc4_o   <= id_pc4_i;
      ex_rd1_o   <= id_rd1_i;
      ex_rd2_o   <= id_rd2_i;
      ex_imm_o   <= id_imm_i;
      ex_rs_o    <= id_rs_i;
      ex_rt_o    <= id_rt_i;
      ex_rd_o    <= id_rd_i;
      ex_ctrl_q  <= id_valid_i ? ctrl_t'(id_ctrl_i) : '0;
      ex_aluop_o <= id_valid_i ? id_aluop_i : '0;
    end
  end

  assign ex_ctrl_o    = ex_ctrl_q;
  assign ex_alu_src_o = ex_ctrl_q.alu_src;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage: scoreboard bench for id_ex_stage against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [5:0]  ctrl;
    logic [3:0]  aluop;
  } in_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  ctrl;
    logic [3:0]  aluop;
    logic        stall;
  } ex_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur;
  ex_t  m;
  ex_t  sb[$];
  logic last_stall;
  int   total = 0;
  int   passed = 0;

  logic        stall_o, ex_valid_o, ex_alu_src_o;
  logic [31:0] ex_pc4_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic [5:0]  ex_ctrl_o;
  logic [3:0]  ex_aluop_o;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (cur.flush),
    .id_valid_i   (cur.valid),
    .id_pc4_i     (cur.pc4),
    .id_rd1_i     (cur.rd1),
    .id_rd2_i     (cur.rd2),
    .id_imm_i     (cur.imm),
    .id_rs_i      (cur.rs),
    .id_rt_i      (cur.rt),
    .id_rd_i      (cur.rd),
    .id_uses_rt_i (cur.uses_rt),
    .id_ctrl_i    (cur.ctrl),
    .id_aluop_i   (cur.aluop),
    .stall_o      (stall_o),
    .ex_valid_o   (ex_valid_o),
    .ex_pc4_o     (ex_pc4_o),
    .ex_rd1_o     (ex_rd1_o),
    .ex_rd2_o     (ex_rd2_o),
    .ex_imm_o     (ex_imm_o),
    .ex_rs_o      (ex_rs_o),
    .ex_rt_o      (ex_rt_o),
    .ex_rd_o      (ex_rd_o),
    .ex_ctrl_o    (ex_ctrl_o),
    .ex_aluop_o   (ex_aluop_o),
    .ex_alu_src_o (ex_alu_src_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ID needs the value a load in EX has not yet fetched from memory
  function automatic logic needs_pending_load(in_t i, ex_t e);
    logic is_load = e.valid && e.ctrl[3] && (e.rt != 5'd0);
    return i.valid && is_load && ((i.rs == e.rt) || (i.uses_rt && i.rt == e.rt));
  endfunction

  // One clock edge: advance the model with what was presented, then present nxt
  task automatic tick(input in_t nxt);
    ex_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m = '{default: '0};
    end else if (cur.flush || needs_pending_load(cur, m)) begin
      m.valid = 1'b0;
      m.ctrl  = '0;
      m.aluop = '0;
    end else begin
      m.valid = cur.valid;
      m.pc4 = cur.pc4; m.rd1 = cur.rd1; m.rd2 = cur.rd2; m.imm = cur.imm;
      m.rs = cur.rs; m.rt = cur.rt; m.rd = cur.rd;
      m.ctrl  = cur.valid ? cur.ctrl : 6'd0;
      m.aluop = cur.valid ? cur.aluop : 4'd0;
    end
    cur = nxt;
    e = m;
    e.stall = rst_n && needs_pending_load(cur, m) && !cur.flush;
    last_stall = e.stall;
    sb.push_back(e);
  endtask

  // Present an instruction and keep re-presenting it while the stage stalls
  task automatic issue(input in_t n);
    int guard = 0;
    tick(n);
    while (last_stall && guard < 4) begin
      guard++;
      tick(n);
    end
  endtask

  function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                             logic [5:0] ctrl, logic flush);
    in_t i;
    i.flush = flush; i.valid = 1'b1;
    i.pc4 = $urandom; i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom;
    i.rs = rs; i.rt = rt; i.rd = 5'($urandom); i.uses_rt = uses_rt;
    i.ctrl = ctrl; i.aluop = 4'($urandom_range(1, 15));
    return i;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    ex_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ex_valid", {31'd0, ex_valid_o}, {31'd0, e.valid});
      chk("ex_ctrl", {26'd0, ex_ctrl_o}, {26'd0, e.ctrl});
      chk("ex_aluop", {28'd0, ex_aluop_o}, {28'd0, e.aluop});
      chk("ex_alu_src", {31'd0, ex_alu_src_o}, {31'd0, e.ctrl[1]});
      chk("stall", {31'd0, stall_o}, {31'd0, e.stall});
      if (e.valid) begin
        chk("ex_pc4", ex_pc4_o, e.pc4);
        chk("ex_rd1", ex_rd1_o, e.rd1);
        chk("ex_rd2", ex_rd2_o, e.rd2);
        chk("ex_imm", ex_imm_o, e.imm);
        chk("ex_regs", {17'd0, ex_rs_o, ex_rt_o, ex_rd_o}, {17'd0, e.rs, e.rt, e.rd});
      end
    end
  end

  localparam logic [5:0] LW  = 6'b111010;
  localparam logic [5:0] ADD = 6'b100001;
  localparam logic [5:0] SW  = 6'b000110;

  initial begin
    in_t i;
    m = '{default: '0};
    last_stall = 1'b0;
    cur = '{flush: 1'b0, valid: 1'b1, pc4: '1, rd1: '1, rd2: '1, imm: '1,
            rs: '1, rt: '1, rd: '1, uses_rt: 1'b1, ctrl: '1, aluop: '1};

    // Reset with all-ones inputs, then release mid-cycle
    tick(cur);
    tick(cur);
    #2 rst_n = 1'b1;

    // ALU-source mux, both selections
    i = mk(5'd1, 5'd2, 1'b1, 6'b100010, 1'b0);
    i.rd2 = 32'h0F25FA0F; i.imm = 32'hF25FA0F0;
    issue(i);
    i.ctrl = 6'b100000;
    issue(i);
    chk("mux_imm", ex_alu_src_o ? ex_imm_o : ex_rd2_o, 32'hF25FA0F0);
    issue(mk(5'd3, 5'd4, 1'b1, ADD, 1'b0));
    chk("mux_rd2", ex_alu_src_o ? ex_imm_o : ex_rd2_o, 32'h0F25FA0F);

    // lw -> add rs, lw -> sw rt, lw $zero -> add $zero, hazard squashed by flush
    issue(mk(5'd1, 5'd8, 1'b0, LW, 1'b0));
    issue(mk(5'd8, 5'd9, 1'b1, ADD, 1'b0));
    issue(mk(5'd1, 5'd8, 1'b0, LW, 1'b0));
    issue(mk(5'd1, 5'd8, 1'b1, SW, 1'b0));
    issue(mk(5'd1, 5'd0, 1'b0, LW, 1'b0));
    issue(mk(5'd0, 5'd0, 1'b1, ADD, 1'b0));
    issue(mk(5'd1, 5'd8, 1'b0, LW, 1'b0));
    issue(mk(5'd8, 5'd9, 1'b1, ADD, 1'b1));
    issue(mk(5'd3, 5'd4, 1'b1, ADD, 1'b0));

    // Async reset pulse while a hazard is being signalled
    issue(mk(5'd1, 5'd8, 1'b0, LW, 1'b0));
    tick(mk(5'd8, 5'd9, 1'b1, ADD, 1'b0));
    @(negedge clk);
    #1;
    chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, ex_valid_o}, 32'd0);
    chk("rst_ctrl", {26'd0, ex_ctrl_o}, 32'd0);
    chk("rst_data", ex_rd2_o | ex_imm_o | ex_pc4_o | ex_rd1_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    m = '{default: '0};
    #1 rst_n = 1'b1;

    // Randomized traffic biased towards register collisions
    for (int n = 0; n < 400; n++) begin
      logic [5:0] c = 6'($urandom);
      if ($urandom_range(0, 2) == 0) c = c | LW;
      i = mk(pick_reg(), pick_reg(), 1'($urandom), c, $urandom_range(0, 9) == 0);
      i.valid = ($urandom_range(0, 9) != 0);
      issue(i);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
